// File: rtl/glb_sync_pkg.sv
// Shared types and default sizing for the global-side PPE sync sequencer.
package glb_sync_pkg;

    localparam int N_PPE_DEF = 4;
    localparam int TMR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } glb_sync_state_t;

endpackage

// File: rtl/glb_sync_tmr.sv
// Saturating phase timer; expiry fires when the count reaches limit-1 and is
// suppressed entirely when the limit is zero.
module glb_sync_tmr
    import glb_sync_pkg::*;
#(
    parameter int TMR_W = TMR_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [TMR_W-1:0] limit_i,
    output logic             expired_o
);

    logic [TMR_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {TMR_W{1'b1}})) begin
            cnt_q <= cnt_q + TMR_W'(1);
        end
    end

    assign expired_o = (limit_i != '0) && (cnt_q == (limit_i - TMR_W'(1)));

endmodule

// File: rtl/glb_rx_ppe_sync_ctrl.sv
// Global-side four-phase sync sequencer: raises glb_sync to the enabled PPEs,
// collects their acks, releases, waits for the acks to drop and reports.
//
// state   | meaning
// IDLE    | ready for a request
// SYNC    | glb_sync high, collecting acks
// RELEASE | glb_sync low, waiting for all acks to drop
// DONE    | one-cycle completion report
module glb_rx_ppe_sync_ctrl
    import glb_sync_pkg::*;
#(
    parameter int N_PPE = N_PPE_DEF,
    parameter int TMR_W = TMR_W_DEF
) (
    input  logic             cclk,
    input  logic             rst,
    input  logic [N_PPE-1:0] cfg_ppe_en,
    input  logic [TMR_W-1:0] cfg_timeout,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic [N_PPE-1:0] err_mask,
    output logic [N_PPE-1:0] glb_sync,
    input  logic [N_PPE-1:0] glb_ack
);

    glb_sync_state_t  state_q;
    logic [N_PPE-1:0] snap_q;
    logic [N_PPE-1:0] ack_seen_q;
    logic [N_PPE-1:0] sync_q;
    logic [N_PPE-1:0] err_mask_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             err_to_q;
    logic             err_flag_q;

    logic [N_PPE-1:0] acks_now;
    logic             all_seen;
    logic             tmr_inc;
    logic             tmr_clr;
    logic             tmr_exp;

    always_comb begin
        acks_now = glb_ack & snap_q;
        all_seen = ((ack_seen_q | acks_now) == snap_q);
        tmr_inc  = (state_q == SYNC) || (state_q == RELEASE);
        tmr_clr  = (state_q == IDLE) || ((state_q == SYNC) && (all_seen || tmr_exp));
    end

    glb_sync_tmr #(.TMR_W(TMR_W)) u_tmr (
        .clk_i     (cclk),
        .rst_i     (rst),
        .clr_i     (tmr_clr),
        .inc_i     (tmr_inc),
        .limit_i   (cfg_timeout),
        .expired_o (tmr_exp)
    );

    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            ack_seen_q <= '0;
            sync_q     <= '0;
            err_mask_q <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_to_q   <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_to_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        snap_q     <= cfg_ppe_en;
                        ack_seen_q <= '0;
                        err_mask_q <= '0;
                        err_flag_q <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        if (cfg_ppe_en == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SYNC;
                            sync_q  <= cfg_ppe_en;
                        end
                    end
                end
                SYNC: begin
                    ack_seen_q <= ack_seen_q | acks_now;
                    // Completion is checked first so a same-cycle timeout is not an error.
                    if (all_seen) begin
                        state_q <= RELEASE;
                        sync_q  <= '0;
                    end else if (tmr_exp) begin
                        err_mask_q <= snap_q & ~(ack_seen_q | glb_ack);
                        err_flag_q <= 1'b1;
                        state_q    <= RELEASE;
                        sync_q     <= '0;
                    end
                end
                RELEASE: begin
                    if (acks_now == '0) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        err_to_q <= err_flag_q;
                    end else if (tmr_exp) begin
                        err_mask_q <= err_mask_q | acks_now;
                        err_flag_q <= 1'b1;
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        err_to_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    ready_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    err_flag_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    sync_q  <= '0;
                end
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_to_q;
    assign err_mask    = err_mask_q;
    assign glb_sync    = sync_q;

endmodule

// File: tb/tb_glb_rx_ppe_sync_ctrl.sv
// Scoreboard bench for glb_rx_ppe_sync_ctrl with a per-PPE ack responder model.
module tb_glb_rx_ppe_sync_ctrl;

    localparam int N  = 4;
    localparam int TW = 16;

    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_STUCK  = 2;
    localparam int M_PULSE  = 3;

    logic          cclk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  cfg_ppe_en = '0;
    logic [TW-1:0] cfg_timeout = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic [N-1:0]  err_mask;
    logic [N-1:0]  glb_sync;
    logic [N-1:0]  glb_ack = '0;

    glb_rx_ppe_sync_ctrl #(.N_PPE(N), .TMR_W(TW)) dut (
        .cclk        (cclk),
        .rst         (rst),
        .cfg_ppe_en  (cfg_ppe_en),
        .cfg_timeout (cfg_timeout),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .err_mask    (err_mask),
        .glb_sync    (glb_sync),
        .glb_ack     (glb_ack)
    );

    always #5 cclk = ~cclk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        string        tag;
        int           lat;
        logic         err;
        logic [N-1:0] mask;
    } exp_t;

    exp_t         sbq[$];
    exp_t         e_m;
    int           cyc = 0;
    int           acc_cyc = -1000;
    int           rel_m;
    int           done_cnt = 0;
    logic [N-1:0] sync_hist[64];
    logic [N-1:0] sync_seen = '0;

    always @(posedge cclk) cyc <= cyc + 1;

    // Monitor: cycle index relative to accept, glb_sync trace, scoreboard pop on done.
    always @(negedge cclk) begin
        if (req_valid && req_ready && !rst) begin
            acc_cyc = cyc;
            foreach (sync_hist[k]) sync_hist[k] = '0;
            sync_seen = '0;
        end
        rel_m = cyc - acc_cyc;
        if (rel_m >= 0 && rel_m < 64) sync_hist[rel_m] = glb_sync;
        sync_seen = sync_seen | glb_sync;
        if (done) begin
            if (sbq.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                e_m = sbq.pop_front();
                chk({e_m.tag, "_lat"}, rel_m, e_m.lat);
                chk({e_m.tag, "_err"}, err_timeout, e_m.err);
                chk({e_m.tag, "_mask"}, err_mask, e_m.mask);
            end
            done_cnt++;
        end
    end

    // PPE responder: ack rises rise_d cycles after sync rises, falls fall_d cycles after it drops.
    int mode[N];
    int rise_d[N];
    int fall_d[N];
    int hi_cnt[N];
    int lo_cnt[N];

    initial begin
        for (int i = 0; i < N; i++) begin
            hi_cnt[i] = 0;
            lo_cnt[i] = 100;
        end
    end

    always @(posedge cclk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (glb_sync[i]) begin
                hi_cnt[i]++;
                lo_cnt[i] = 0;
            end else begin
                lo_cnt[i]++;
                hi_cnt[i] = 0;
            end
            case (mode[i])
                M_NEVER: glb_ack[i] = 1'b0;
                M_STUCK: glb_ack[i] = 1'b1;
                M_PULSE: glb_ack[i] = (hi_cnt[i] == rise_d[i] + 1);
                default: begin
                    if (hi_cnt[i] >= rise_d[i] + 1)      glb_ack[i] = 1'b1;
                    else if (lo_cnt[i] >= fall_d[i] + 1) glb_ack[i] = 1'b0;
                end
            endcase
        end
    end

    task automatic set_all(input int m, input int r, input int f);
        for (int i = 0; i < N; i++) begin
            mode[i] = m;
            rise_d[i] = r;
            fall_d[i] = f;
        end
    endtask

    task automatic run_req(input string tag, input logic [N-1:0] en, input logic [TW-1:0] to,
                           input int lat, input logic err, input logic [N-1:0] mask, input bit push);
        exp_t e;
        repeat (2) @(posedge cclk);
        #1;
        cfg_ppe_en  = en;
        cfg_timeout = to;
        req_valid   = 1'b1;
        if (push) begin
            e.tag = tag; e.lat = lat; e.err = err; e.mask = mask;
            sbq.push_back(e);
        end
        @(posedge cclk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 200) begin
            @(posedge cclk);
            n++;
        end
        if (done_cnt == start) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        #1;
    endtask

    int dc;

    initial begin
        set_all(M_NORMAL, 2, 1);
        repeat (3) @(posedge cclk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sync", glb_sync, 0);
        chk("rst_mask", err_mask, 0);
        chk("rst_err", err_timeout, 0);
        rst = 1'b0;

        // Basic sequence; cfg_ppe_en change mid-sequence must have no effect.
        run_req("t1", 4'hF, 0, 6, 1'b0, 4'h0, 1'b1);
        cfg_ppe_en = 4'h0;
        chk("t1_busy", busy, 1);
        wait_done("t1");
        chk("t1_sync_c1", sync_hist[1], 4'hF);
        chk("t1_sync_c3", sync_hist[3], 4'hF);
        chk("t1_sync_c4", sync_hist[4], 4'h0);
        chk("t1_ready_after", req_ready, 1);

        // Staggered acks with PPE0 pulsing early.
        set_all(M_NORMAL, 3, 1);
        mode[0] = M_PULSE; rise_d[0] = 1;
        rise_d[3] = 8;
        run_req("t2", 4'hF, 0, 12, 1'b0, 4'h0, 1'b1);
        wait_done("t2");
        chk("t2_sync_c9", sync_hist[9], 4'hF);
        chk("t2_sync_c10", sync_hist[10], 4'h0);

        // Partial enable; disabled PPE1 holds ack high.
        set_all(M_NORMAL, 2, 1);
        mode[1] = M_STUCK;
        run_req("t3", 4'b0101, 0, 6, 1'b0, 4'h0, 1'b1);
        wait_done("t3");
        chk("t3_sync_c1", sync_hist[1], 4'b0101);
        chk("t3_no_sync_13", sync_seen & 4'b1010, 4'h0);

        // SYNC timeout with PPE2 silent.
        set_all(M_NORMAL, 2, 1);
        mode[2] = M_NEVER;
        run_req("t4", 4'hF, 8, 11, 1'b1, 4'b0100, 1'b1);
        wait_done("t4");
        chk("t4_sync_c8", sync_hist[8], 4'hF);
        chk("t4_sync_c9", sync_hist[9], 4'h0);
        repeat (3) @(posedge cclk);
        #1;
        chk("t4_mask_held", err_mask, 4'b0100);

        // RELEASE timeout with PPE1 stuck high.
        set_all(M_NORMAL, 2, 1);
        mode[1] = M_STUCK;
        run_req("t5", 4'hF, 5, 9, 1'b1, 4'b0010, 1'b1);
        wait_done("t5");
        chk("t5_ready_after", req_ready, 1);

        // Completion on the same cycle as expiry: no error.
        set_all(M_NORMAL, 2, 1);
        run_req("t6", 4'hF, 3, 6, 1'b0, 4'h0, 1'b1);
        wait_done("t6");

        // Timeout of 1 expires on the first SYNC cycle.
        run_req("t7", 4'hF, 1, 3, 1'b1, 4'hF, 1'b1);
        wait_done("t7");
        chk("t7_sync_c2", sync_hist[2], 4'h0);

        // Empty enable set.
        run_req("t8", 4'h0, 0, 1, 1'b0, 4'h0, 1'b1);
        wait_done("t8");
        chk("t8_no_sync", sync_seen, 4'h0);

        // Reset in the middle of SYNC.
        set_all(M_NEVER, 2, 1);
        dc = done_cnt;
        run_req("t9", 4'hF, 0, 0, 1'b0, 4'h0, 1'b0);
        repeat (2) @(posedge cclk);
        #1;
        chk("t9_sync_before", glb_sync, 4'hF);
        rst = 1'b1;
        @(posedge cclk);
        #1;
        chk("t9_sync_rst", glb_sync, 4'h0);
        chk("t9_busy_rst", busy, 0);
        chk("t9_ready_rst", req_ready, 1);
        rst = 1'b0;
        repeat (3) @(posedge cclk);
        #1;
        chk("t9_no_done", done_cnt, dc);
        set_all(M_NORMAL, 2, 1);
        run_req("t9_post", 4'hF, 0, 6, 1'b0, 4'h0, 1'b1);
        wait_done("t9_post");

        chk("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
